// File: rtl/bayer_window3x3.sv
// -----------------------------------------------------------------------------
// bayer_window3x3
//   Streaming 3x3 neighbourhood generator for raw 8-bit Bayer video. Two line
//   buffers hold the previous two lines; each accepted pixel that completes a
//   full window (row >= 2, col >= 2) produces one 72-bit raster-ordered window
//   plus the colour-phase code of the window centre, two clocks later.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_data    raw Bayer pixel
//   in_valid   qualifies in_data / in_sof / in_eol (may be gapped)
//   in_sof     first pixel of a frame (restarts at row 0, col 0)
//   in_eol     last pixel of a line
//   out_data   byte 3r+c = p(r,c); r=0 oldest line, c=0 oldest column
//   out_valid  one-cycle strobe per window
//   out_mode   centre colour: 10 R, 00 G(red row), 11 G(blue row), 01 B
// -----------------------------------------------------------------------------
module bayer_window3x3 #(
  parameter int         MAX_WIDTH   = 640,
  parameter int         COL_BITS    = 10,
  parameter logic [1:0] BAYER_PHASE = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eol,
  output logic [71:0] out_data,
  output logic        out_valid,
  output logic [1:0]  out_mode
);

  localparam int                  AW      = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(MAX_WIDTH);
  localparam int                  STAGES  = 2;

  typedef enum logic {WAIT_SOF, ACTIVE} state_e;

  typedef struct packed {
    logic [7:0] pix;
    logic [1:0] mode;
  } s1_t;

  // ---------------------------------------------------------------------------
  // Position tracking
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [COL_BITS-1:0] col_q, col_d, cur_col;
  logic [1:0]          row_q, row_d, cur_row;   // saturates at 2
  logic                rpar_q, rpar_d, cur_par; // true row parity
  logic                accept, keep, emit;
  logic [1:0]          mode_c;
  logic [AW-1:0]       addr;

  // A pixel with in_sof is always (0,0), whatever the tracked position says.
  always_comb begin
    accept  = in_valid && (in_sof || (state_q == ACTIVE));
    cur_col = in_sof ? '0   : col_q;
    cur_row = in_sof ? '0   : row_q;
    cur_par = in_sof ? 1'b0 : rpar_q;
    // col saturates at MAX_WIDTH, so anything past the buffer depth is dropped
    keep    = accept && (cur_col < COL_MAX);
    emit    = keep && (cur_row == 2'd2) && (cur_col >= COL_BITS'(2));
    addr    = cur_col[AW-1:0];
    // Centre sits at (row-1, col-1): its parity bits are the inverted current ones.
    unique case ({~cur_par ^ BAYER_PHASE[1], ~cur_col[0] ^ BAYER_PHASE[0]})
      2'b00:   mode_c = 2'b10;
      2'b01:   mode_c = 2'b00;
      2'b10:   mode_c = 2'b11;
      default: mode_c = 2'b01;
    endcase
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    rpar_d  = rpar_q;
    if (accept) begin
      state_d = ACTIVE;
      if (in_eol) begin
        col_d  = '0;
        row_d  = (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
        rpar_d = ~cur_par;
      end else begin
        col_d  = (cur_col >= COL_MAX) ? COL_MAX : cur_col + COL_BITS'(1);
        row_d  = cur_row;
        rpar_d = cur_par;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: line buffers (read-before-write) and pixel/mode capture
  // ---------------------------------------------------------------------------
  logic [7:0]        line1 [MAX_WIDTH];
  logic [7:0]        line2 [MAX_WIDTH];
  logic [7:0]        l1_rd_q, l2_rd_q;
  s1_t               s1_q, s1_d;
  logic              shift_q;
  logic [STAGES:1]   vld_pipe_q;

  // The old line-1 word cascades into line-2 in the same cycle it is read out.
  always_ff @(posedge clk) begin
    if (keep) begin
      l1_rd_q     <= line1[addr];
      l2_rd_q     <= line2[addr];
      line1[addr] <= in_data;
      line2[addr] <= line1[addr];
    end
  end

  always_comb begin
    s1_d = s1_q;
    if (keep) begin
      s1_d.pix  = in_data;
      s1_d.mode = mode_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: per-row column shift registers and output register
  // ---------------------------------------------------------------------------
  logic [2:0][2:0][7:0] sr_q, sr_d;  // [row][col], col 2 newest
  logic [71:0]          out_data_q, out_data_d;
  logic [1:0]           out_mode_q, out_mode_d;

  always_comb begin
    sr_d = sr_q;
    if (shift_q) begin
      for (int r = 0; r < 3; r++) begin
        sr_d[r][0] = sr_q[r][1];
        sr_d[r][1] = sr_q[r][2];
      end
      sr_d[0][2] = l2_rd_q;
      sr_d[1][2] = l1_rd_q;
      sr_d[2][2] = s1_q.pix;
    end
    // [row][col][byte] packing already places p(r,c) at byte 3r+c.
    out_data_d = vld_pipe_q[1] ? sr_d      : out_data_q;
    out_mode_d = vld_pipe_q[1] ? s1_q.mode : out_mode_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_SOF;
      col_q      <= '0;
      row_q      <= '0;
      rpar_q     <= 1'b0;
      s1_q       <= '0;
      shift_q    <= 1'b0;
      vld_pipe_q <= '0;
      sr_q       <= '0;
      out_data_q <= '0;
      out_mode_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rpar_q     <= rpar_d;
      s1_q       <= s1_d;
      shift_q    <= keep;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], emit};
      sr_q       <= sr_d;
      out_data_q <= out_data_d;
      out_mode_q <= out_mode_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;
  assign out_valid = vld_pipe_q[STAGES];

endmodule

// File: tb/tb_bayer_window3x3.sv
// -----------------------------------------------------------------------------
// tb_bayer_window3x3
//   Three DUT instances share one input stream: default parameters, phase 11,
//   and an 8-pixel line buffer. A reference model keeps the last three image
//   rows by true row index and derives each window directly from the image.
// -----------------------------------------------------------------------------
module tb_bayer_window3x3;

  typedef struct packed {
    int          cyc;
    logic [71:0] data;
    logic [1:0]  mode;
  } win_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0;

  logic [71:0] od [3];
  logic        ov [3];
  logic [1:0]  om [3];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  win_t exp_q [3][$];
  win_t obs_q [3][$];

  logic [7:0] img [3][16];
  int         m_row = 0, m_col = 0;
  bit         m_active = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bayer_window3x3 dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_eol(in_eol),
    .out_data(od[0]), .out_valid(ov[0]), .out_mode(om[0]));

  bayer_window3x3 #(.BAYER_PHASE(2'b11)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_eol(in_eol),
    .out_data(od[1]), .out_valid(ov[1]), .out_mode(om[1]));

  bayer_window3x3 #(.MAX_WIDTH(8), .COL_BITS(4)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_eol(in_eol),
    .out_data(od[2]), .out_valid(ov[2]), .out_mode(om[2]));

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++)
      if (ov[d] === 1'b1) obs_q[d].push_back('{cyc, od[d], om[d]});
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic win_t mk_win(int r, int c, logic [1:0] ph);
    win_t w;
    int   rp, cp;
    w.cyc  = cyc + 2;
    w.data = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w.data[8*(3*rr+cc) +: 8] = img[(r-2+rr) % 3][c-2+cc];
    rp = ((r - 1) % 2) ^ int'(ph[1]);
    cp = ((c - 1) % 2) ^ int'(ph[0]);
    case ({rp[0], cp[0]})
      2'b00:   w.mode = 2'b10;
      2'b01:   w.mode = 2'b00;
      2'b10:   w.mode = 2'b11;
      default: w.mode = 2'b01;
    endcase
    return w;
  endfunction

  task automatic px(input logic [7:0] d, input bit sof, input bit eol);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_sof = sof; in_eol = eol;
    if (sof) begin m_active = 1'b1; m_row = 0; m_col = 0; end
    if (m_active) begin
      if (m_col < 16) img[m_row % 3][m_col] = d;
      if (m_row >= 2 && m_col >= 2 && m_col < 16) begin
        exp_q[0].push_back(mk_win(m_row, m_col, 2'b00));
        exp_q[1].push_back(mk_win(m_row, m_col, 2'b11));
        if (m_col < 8) exp_q[2].push_back(mk_win(m_row, m_col, 2'b00));
      end
      if (eol) begin m_row++; m_col = 0; end
      else m_col++;
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    end
  endtask

  // gap: 0 full rate, 1 alternate cycles + 5-cycle gap at eol, 2 random
  task automatic frame(int h, int w, logic [7:0] base, int gap, bit rnd);
    logic [7:0] d;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        d = rnd ? 8'($urandom) : base + 8'(16*r + c);
        px(d, (r == 0 && c == 0), (c == w-1));
        if (gap == 1) idle((c == w-1) ? 5 : 1);
        else if (gap == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    // windows not yet visible when reset is sampled are lost
    for (int d = 0; d < 3; d++)
      for (int i = exp_q[d].size() - 1; i >= 0; i--)
        if (exp_q[d][i].cyc > cyc) exp_q[d].delete(i);
    m_active = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear();
    for (int d = 0; d < 3; d++) begin
      exp_q[d].delete();
      obs_q[d].delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear();
    do_reset(2);
    for (int i = 0; i < 23; i++) begin
      if (i < 20) px(8'($urandom), 1'b0, (i % 5 == 4));
      else idle(1);
      n_chk++;
      if (ov[0] !== 1'b0 || ov[2] !== 1'b0) begin
        n_fail++; $display("FAIL reset_valid[%0d]: got %b/%b want 0", i, ov[0], ov[2]);
      end
      n_chk++;
      if (od[0] !== 72'h0) begin
        n_fail++; $display("FAIL reset_data[%0d]: got %h want 0", i, od[0]);
      end
      n_chk++;
      if (om[0] !== 2'b00) begin
        n_fail++; $display("FAIL reset_mode[%0d]: got %b want 00", i, om[0]);
      end
    end
  endtask

  task automatic test_full_rate();
    logic [1:0] modes [4];
    modes = '{2'b01, 2'b11, 2'b00, 2'b10};
    clear();
    frame(4, 4, 8'h00, 0, 1'b0);
    idle(6);
    n_chk++;
    if (obs_q[0].size() != 4) begin
      n_fail++; $display("FAIL full_rate_count: got %0d want 4", obs_q[0].size());
    end
    for (int i = 0; i < obs_q[0].size() && i < 4 && i < exp_q[0].size(); i++) begin
      n_chk++;
      if (obs_q[0][i] !== exp_q[0][i]) begin
        n_fail++;
        $display("FAIL full_rate_win[%0d]: got cyc=%0d data=%h mode=%b want cyc=%0d data=%h mode=%b",
                 i, obs_q[0][i].cyc, obs_q[0][i].data, obs_q[0][i].mode,
                 exp_q[0][i].cyc, exp_q[0][i].data, exp_q[0][i].mode);
      end
      n_chk++;
      if (obs_q[0][i].mode !== modes[i]) begin
        n_fail++; $display("FAIL full_rate_mode[%0d]: got %b want %b", i, obs_q[0][i].mode, modes[i]);
      end
    end
    if (obs_q[0].size() > 0) begin
      n_chk++;
      if (obs_q[0][0].data !== 72'h22_21_20_12_11_10_02_01_00) begin
        n_fail++; $display("FAIL full_rate_first: got %h want 222120121110020100", obs_q[0][0].data);
      end
    end
  endtask

  task automatic test_gapped();
    logic [1:0] modes [4];
    modes = '{2'b01, 2'b11, 2'b00, 2'b10};
    clear();
    frame(4, 4, 8'h00, 1, 1'b0);
    idle(6);
    n_chk++;
    if (obs_q[0].size() != 4) begin
      n_fail++; $display("FAIL gapped_count: got %0d want 4", obs_q[0].size());
    end
    for (int i = 0; i < obs_q[0].size() && i < 4 && i < exp_q[0].size(); i++) begin
      n_chk++;
      if (obs_q[0][i] !== exp_q[0][i]) begin
        n_fail++;
        $display("FAIL gapped_win[%0d]: got cyc=%0d data=%h mode=%b want cyc=%0d data=%h mode=%b",
                 i, obs_q[0][i].cyc, obs_q[0][i].data, obs_q[0][i].mode,
                 exp_q[0][i].cyc, exp_q[0][i].data, exp_q[0][i].mode);
      end
      n_chk++;
      if (obs_q[0][i].mode !== modes[i]) begin
        n_fail++; $display("FAIL gapped_mode[%0d]: got %b want %b", i, obs_q[0][i].mode, modes[i]);
      end
    end
  endtask

  task automatic test_phase();
    logic [1:0] modes [4];
    modes = '{2'b10, 2'b00, 2'b11, 2'b01};
    clear();
    frame(4, 4, 8'h00, 0, 1'b0);
    idle(6);
    n_chk++;
    if (obs_q[1].size() != 4) begin
      n_fail++; $display("FAIL phase_count: got %0d want 4", obs_q[1].size());
    end
    for (int i = 0; i < obs_q[1].size() && i < 4 && i < exp_q[1].size(); i++) begin
      n_chk++;
      if (obs_q[1][i] !== exp_q[1][i]) begin
        n_fail++;
        $display("FAIL phase_win[%0d]: got cyc=%0d data=%h mode=%b want cyc=%0d data=%h mode=%b",
                 i, obs_q[1][i].cyc, obs_q[1][i].data, obs_q[1][i].mode,
                 exp_q[1][i].cyc, exp_q[1][i].data, exp_q[1][i].mode);
      end
      n_chk++;
      if (obs_q[1][i].mode !== modes[i]) begin
        n_fail++; $display("FAIL phase_mode[%0d]: got %b want %b", i, obs_q[1][i].mode, modes[i]);
      end
    end
  endtask

  task automatic test_sof_midframe();
    logic [8:0] hi;
    clear();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 6; c++) px(8'(16*r + c), (r == 0 && c == 0), (c == 5));
    px(8'h20, 1'b0, 1'b0);
    frame(6, 6, 8'h80, 0, 1'b0);  // its first pixel is old (2,1) carrying in_sof
    idle(6);
    n_chk++;
    if (obs_q[0].size() != 16) begin
      n_fail++; $display("FAIL sof_mid_count: got %0d want 16", obs_q[0].size());
    end
    for (int i = 0; i < obs_q[0].size() && i < exp_q[0].size(); i++) begin
      n_chk++;
      if (obs_q[0][i] !== exp_q[0][i]) begin
        n_fail++;
        $display("FAIL sof_mid_win[%0d]: got cyc=%0d data=%h mode=%b want cyc=%0d data=%h mode=%b",
                 i, obs_q[0][i].cyc, obs_q[0][i].data, obs_q[0][i].mode,
                 exp_q[0][i].cyc, exp_q[0][i].data, exp_q[0][i].mode);
      end
      for (int k = 0; k < 9; k++) hi[k] = obs_q[0][i].data[8*k+7];
      n_chk++;
      if (hi !== 9'h1FF) begin
        n_fail++; $display("FAIL sof_mid_newdata[%0d]: got %h want all bytes >= 80", i, obs_q[0][i].data);
      end
    end
  endtask

  task automatic test_overlong();
    clear();
    frame(3, 10, 8'h00, 0, 1'b0);
    idle(6);
    n_chk++;
    if (obs_q[2].size() != 6) begin
      n_fail++; $display("FAIL overlong_count: got %0d want 6", obs_q[2].size());
    end
    for (int i = 0; i < obs_q[2].size() && i < exp_q[2].size(); i++) begin
      n_chk++;
      if (obs_q[2][i] !== exp_q[2][i]) begin
        n_fail++;
        $display("FAIL overlong_win[%0d]: got cyc=%0d data=%h mode=%b want cyc=%0d data=%h mode=%b",
                 i, obs_q[2][i].cyc, obs_q[2][i].data, obs_q[2][i].mode,
                 exp_q[2][i].cyc, exp_q[2][i].data, exp_q[2][i].mode);
      end
      n_chk++;
      if (obs_q[2][i].data[71:64] !== 8'h20 + 8'(i + 2)) begin
        n_fail++; $display("FAIL overlong_col[%0d]: got %h want %h", i, obs_q[2][i].data[71:64], 8'h20 + 8'(i + 2));
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) px(8'(16*r + c), (r == 0 && c == 0), (c == 3));
    do_reset(2);
    for (int i = 0; i < 8; i++) px(8'($urandom), 1'b0, (i % 4 == 3));
    frame(4, 4, 8'h40, 0, 1'b0);
    idle(6);
    n_chk++;
    if (obs_q[0].size() != 5) begin
      n_fail++; $display("FAIL reset_mid_count: got %0d want 5", obs_q[0].size());
    end
    for (int i = 0; i < obs_q[0].size() && i < exp_q[0].size(); i++) begin
      n_chk++;
      if (obs_q[0][i] !== exp_q[0][i]) begin
        n_fail++;
        $display("FAIL reset_mid_win[%0d]: got cyc=%0d data=%h mode=%b want cyc=%0d data=%h mode=%b",
                 i, obs_q[0][i].cyc, obs_q[0][i].data, obs_q[0][i].mode,
                 exp_q[0][i].cyc, exp_q[0][i].data, exp_q[0][i].mode);
      end
    end
  endtask

  task automatic test_random();
    clear();
    for (int f = 0; f < 6; f++)
      frame($urandom_range(3, 6), $urandom_range(3, 10), 8'h00, 2, 1'b1);
    idle(6);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (obs_q[d].size() != exp_q[d].size()) begin
        n_fail++; $display("FAIL random_count dut%0d: got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
      end
      for (int i = 0; i < obs_q[d].size() && i < exp_q[d].size(); i++) begin
        n_chk++;
        if (obs_q[d][i] !== exp_q[d][i]) begin
          n_fail++;
          $display("FAIL random_win dut%0d[%0d]: got cyc=%0d data=%h mode=%b want cyc=%0d data=%h mode=%b",
                   d, i, obs_q[d][i].cyc, obs_q[d][i].data, obs_q[d][i].mode,
                   exp_q[d][i].cyc, exp_q[d][i].data, exp_q[d][i].mode);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_gapped();
    test_phase();
    test_sof_midframe();
    test_overlong();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bayer_window3x3.md
# bayer_window3x3

Streaming 3x3 neighbourhood generator for raw 8-bit Bayer video. It sits between the camera pixel capture and the demosaic stage. It buffers two previous lines and packs each full 3x3 window into the 72-bit raster-ordered word that the demosaic stage consumes. Alongside each window it emits the 2-bit colour-phase code of the window's centre pixel.

## Interface
- `MAX_WIDTH`, default 640: maximum pixels per line; sets the line-buffer depth.
- `COL_BITS`, default 10: column counter width; must satisfy 2^COL_BITS > MAX_WIDTH.
- `BAYER_PHASE`, default 2'b00: {row, col} parity XOR applied before the mode lookup. 2'b00 means pixel (0,0) is red (RGGB).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  raw Bayer pixel.
- `in_valid`  in  1  qualifies `in_data`, `in_sof`, `in_eol`; may be gapped arbitrarily.
- `in_sof`  in  1  first pixel of a frame; meaningful only with `in_valid`.
- `in_eol`  in  1  last pixel of a line; meaningful only with `in_valid`.
- `out_data`  out  72  3x3 window; byte k = [8k+7:8k] holds p(r,c) with k = 3r + c. r=0 is the oldest line (top), c=0 is the oldest column (left). Centre is [39:32].
- `out_valid`  out  1  one-cycle strobe per window.
- `out_mode`  out  2  centre colour code: 2'b10 R, 2'b00 G on a red row, 2'b11 G on a blue row, 2'b01 B.

## Operation
- The block has no backpressure; every accepted pixel is consumed.
- FSM states:
  - WAIT_SOF (reset state): all pixels are ignored unless `in_sof` is high.
  - ACTIVE: entered on any `in_valid && in_sof`.
- Counters:
  - `col` holds the current pixel's column. `row` holds the row index, saturating at 2, plus a separate row-parity bit.
  - A pixel with `in_sof` is (row 0, col 0), even in ACTIVE; this restarts the frame.
  - A pixel with `in_eol` causes the next pixel to take col=0 and row+1.
  - `in_sof && in_eol` together form a one-pixel line.
- Line buffers:
  - Two MAX_WIDTH x 8 RAMs (line-1 and line-2), addressed by `col`, with read-before-write.
  - The incoming pixel is written to line-1; the old line-1 word at that address moves to line-2.
  - Three 3-deep shift registers (one per row) shift on each accepted pixel.
- Window emission:
  - A window is emitted for an accepted pixel whose row >= 2 and col >= 2. That pixel becomes p(2,2).
  - The centre is at (row-1, col-1), so a frame of H x W yields (H-2)x(W-2) windows.
- Mode:
  - Let rp = (row-1)[0] ^ BAYER_PHASE[1] and cp = (col-1)[0] ^ BAYER_PHASE[0].
  - {rp,cp} maps as: 00 -> 2'b10, 01 -> 2'b00, 10 -> 2'b11, 11 -> 2'b01.
- Overlong line: a pixel arriving with col >= MAX_WIDTH is dropped. It is not written and produces no output. `col` saturates at MAX_WIDTH until `in_eol` or `in_sof`.
- Line-buffer contents are never cleared. Stale data is never emitted, because of the row >= 2 gate.

## Timing
- Latency: `out_valid` pulses exactly 2 clocks after the `in_valid` cycle of the completing pixel.
  - Cycle 1: RAM read and shift.
  - Cycle 2: output register.
- `out_data` and `out_mode` are stable while `out_valid` is high. They hold their last value otherwise.
- Gaps in `in_valid` insert identical gaps in `out_valid`. Throughput is one window per clock at full rate.
- Reset values: `out_valid`=0, `out_data`=72'h0, `out_mode`=2'b00, FSM=WAIT_SOF, counters=0.
- Reset mid-frame:
  - `out_valid` is 0 from the first clock after `rst` is sampled high.
  - In-flight windows are discarded.
  - Output resumes only after a new `in_sof` plus two further lines.
- `in_sof` mid-frame: in-flight windows from the old frame still emit on schedule. No new windows appear until row 2 of the new frame.

## Test plan
- Reset:
  - Assert `rst` for 2 clocks, then drive 20 valid pixels without `in_sof`.
  - Required: `out_valid` stays 0, and `out_data`=0, `out_mode`=00 throughout.
- 4x4 frame at full rate, pixel value = 16*row + col, BAYER_PHASE=00:
  - Exactly 4 windows, each 2 clocks after pixels (2,2), (2,3), (3,2), (3,3).
  - First window: `out_data`=72'h22_21_20_12_11_10_02_01_00, `out_mode`=01.
  - Remaining windows in order: `out_mode` = 11, 00, 10.
- Same frame with `in_valid` high on alternate cycles and a 5-cycle gap at each `in_eol`:
  - Identical `out_data`/`out_mode` sequence.
  - Each `out_valid` exactly 2 clocks after its completing pixel.
- BAYER_PHASE=2'b11 with the 4x4 frame:
  - Modes in order are 10, 00, 11, 01.
- `in_sof` issued on pixel (2,1) of a 6x6 frame:
  - The window for old pixel (2,0) is not emitted, since col < 2.
  - No `out_valid` until the new frame's pixel (2,2); then windows contain only new-frame data.
- MAX_WIDTH=8: send a 3-row frame with 10 pixels per line:
  - Pixels at cols 8 and 9 are dropped.
  - Exactly 6 windows, with p(2,2) columns 2..7.
  - The line after the overlong line restarts at col 0 with correct alignment.
